// File: rtl/tag_lookup_issue_pkg.sv
// Shared request layout and AR handshake state encoding for the tag path.
// No logic: field positions and types only.
// Reused by tag lookup/issue, the tag comparator and the reorder buffer.
package tag_lookup_issue_pkg;

    // Request word layout: {is_write, id[15:0], byte_addr[63:0]}
    localparam int REQ_W        = 81;
    localparam int IS_WRITE_BIT = 80;
    localparam int ID_MSB       = 79;
    localparam int ID_LSB       = 64;
    localparam int ADDR_MSB     = 63;
    localparam int ADDR_LSB     = 0;

    // AR channel handshake state
    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_VALID = 1'b1
    } ar_state_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO with occupancy count, full and empty flags.
// Latency: push visible at head the cycle after the write edge; head is combinational.
// Backpressure: push ignored when full, pop ignored when empty; empty head reads as zero.
module req_fifo #(
    parameter int WIDTH = 81,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage write; data words need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at a power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tag_lookup_issue.sv
// Accepts host requests, issues the tag-entry AXI read and queues the request for the comparator.
// Latency: accept at edge N -> arvalid_o and fifo_valid_o high from cycle N+1.
// Backpressure: req_ready_o drops when the FIFO is full or an AR is pending without arready_i.
module tag_lookup_issue
    import tag_lookup_issue_pkg::*;
#(
    parameter int          TAG_BIT_SIZE  = 8,
    parameter int          LINE_BITS     = 6,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [63:0] TAG_BASE_ADDR = 64'h0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [REQ_W-1:0]              req_data_i,
    output logic [63:0]                   araddr_o,
    output logic                          arvalid_o,
    input  logic                          arready_i,
    output logic [REQ_W-1:0]              fifo_data_o,
    output logic                          fifo_valid_o,
    input  logic                          fifo_pop_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          err_o
);

    localparam int IDX_LO = ADDR_LSB + LINE_BITS;
    localparam int IDX_HI = ADDR_LSB + TAG_BIT_SIZE - 1;

    ar_state_t   state;
    ar_state_t   state_next;
    logic        accept;
    logic        fifo_full;
    logic        fifo_empty;
    logic [63:0] araddr_next;

    // Each tag entry is 8 bytes, indexed by the set bits between line offset and tag.
    assign araddr_next = TAG_BASE_ADDR + (64'(req_data_i[IDX_HI:IDX_LO]) << 3);

    // Only the registered count gates readiness, so a same-cycle pop cannot unblock a full FIFO.
    assign req_ready_o  = !rst && !fifo_full && (state == AR_IDLE || arready_i);
    assign accept       = req_valid_i && req_ready_o;
    assign arvalid_o    = (state == AR_VALID);
    assign fifo_valid_o = !fifo_empty;

    // Next AR state: a new accept keeps the channel busy, a lone handshake frees it.
    always_comb begin
        state_next = state;
        case (state)
            AR_IDLE: begin
                if (accept) begin
                    state_next = AR_VALID;
                end
            end
            AR_VALID: begin
                if (accept) begin
                    state_next = AR_VALID;
                end else if (arready_i) begin
                    state_next = AR_IDLE;
                end
            end
            default: state_next = AR_IDLE;
        endcase
    end

    // AR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= AR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // AR address loads only on accept, so it holds while the slave stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            araddr_o <= '0;
        end else if (accept) begin
            araddr_o <= araddr_next;
        end
    end

    // Sticky underflow: comparator popped with nothing queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (fifo_pop_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

    req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (req_data_i),
        .pop       (fifo_pop_i),
        .head_data (fifo_data_o),
        .count     (count_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_tag_lookup_issue.sv
// Directed bench for tag_lookup_issue with a queue scoreboard for AR addresses and FIFO order.
// One stimulus step per clock; outputs sampled mid-cycle, inputs driven after the rising edge.
// Exercises stall, full FIFO, wrap, underflow and reset paths.
module tb_tag_lookup_issue;

    logic         clk;
    logic         rst;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [80:0]  req_data_i;
    logic [63:0]  araddr_o;
    logic         arvalid_o;
    logic         arready_i;
    logic [80:0]  fifo_data_o;
    logic         fifo_valid_o;
    logic         fifo_pop_i;
    logic [3:0]   count_o;
    logic         err_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int           m_cnt;
    logic         m_arv;
    logic         m_err;
    logic [80:0]  fifo_q[$];
    logic [63:0]  ar_q[$];
    logic [15:0]  next_id;

    tag_lookup_issue #(
        .TAG_BIT_SIZE  (8),
        .LINE_BITS     (6),
        .FIFO_DEPTH    (8),
        .TAG_BASE_ADDR (64'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_data_i   (req_data_i),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .fifo_data_o  (fifo_data_o),
        .fifo_valid_o (fifo_valid_o),
        .fifo_pop_i   (fifo_pop_i),
        .count_o      (count_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] exp_ar(input logic [63:0] addr);
        logic [1:0] set_idx;
        set_idx = addr[7:6];
        return 64'h0 + 64'(set_idx) * 64'd8;
    endfunction

    function automatic logic [80:0] mk_req(input logic wr, input logic [15:0] id, input logic [63:0] addr);
        return {wr, id, addr};
    endfunction

    task automatic check(input string tag, input logic [80:0] obs, input logic [80:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_req(output logic [80:0] r);
        logic [63:0] a;
        a = {$urandom, $urandom};
        r = mk_req(1'($urandom_range(0, 1)), next_id, a);
        next_id++;
    endtask

    // One clock of stimulus: drive, check against the model, update the scoreboard, advance.
    task automatic cycle(input logic v, input logic [80:0] d, input logic ar, input logic p);
        logic exp_rdy;
        logic acc;
        req_valid_i = v;
        req_data_i  = d;
        arready_i   = ar;
        fifo_pop_i  = p;
        #1;
        exp_rdy = (m_cnt < 8) && (!m_arv || ar);
        check("req_ready", 81'(req_ready_o), 81'(exp_rdy));
        check("count", 81'(count_o), 81'(m_cnt));
        check("arvalid", 81'(arvalid_o), 81'(m_arv));
        check("fifo_valid", 81'(fifo_valid_o), 81'(m_cnt != 0));
        check("err", 81'(err_o), 81'(m_err));
        if (m_arv) check("araddr", 81'(araddr_o), 81'(ar_q[0]));
        if (m_cnt != 0) check("fifo_head", fifo_data_o, fifo_q[0]);
        else            check("fifo_empty_data", fifo_data_o, 81'(0));
        acc = v && exp_rdy;
        if (m_arv && ar) void'(ar_q.pop_front());
        if (p) begin
            if (m_cnt != 0) begin
                void'(fifo_q.pop_front());
                m_cnt--;
            end else begin
                m_err = 1'b1;
            end
        end
        if (acc) begin
            fifo_q.push_back(d);
            ar_q.push_back(exp_ar(d[63:0]));
            m_cnt++;
        end
        if (acc)     m_arv = 1'b1;
        else if (ar) m_arv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req_valid_i = 1'b1;
        req_data_i  = '0;
        arready_i   = 1'b1;
        fifo_pop_i  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_count", 81'(count_o), 81'(0));
        check("rst_arvalid", 81'(arvalid_o), 81'(0));
        check("rst_araddr", 81'(araddr_o), 81'(0));
        check("rst_fifo_valid", 81'(fifo_valid_o), 81'(0));
        check("rst_err", 81'(err_o), 81'(0));
        check("rst_ready", 81'(req_ready_o), 81'(0));
        m_cnt = 0;
        m_arv = 1'b0;
        m_err = 1'b0;
        fifo_q.delete();
        ar_q.delete();
        rst         = 1'b0;
        req_valid_i = 1'b0;
    endtask

    initial begin
        logic [80:0] r;
        next_id     = 16'h0100;
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_data_i  = '0;
        arready_i   = 1'b0;
        fifo_pop_i  = 1'b0;
        m_cnt = 0;
        m_arv = 1'b0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single read at 0xC0: tag entry address 0x18, one AR beat, one queued request
        r = mk_req(1'b0, 16'h0001, 64'h0000_0000_0000_00C0);
        cycle(1'b1, r, 1'b1, 1'b0);
        check("c0_araddr", 81'(araddr_o), 81'(64'h18));
        check("c0_count", 81'(count_o), 81'(1));
        check("c0_is_write", 81'(fifo_data_o[80]), 81'(0));
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("c0_arvalid_drop", 81'(arvalid_o), 81'(0));
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Slave stall: AR held 5 cycles, further requests refused
        new_req(r);
        cycle(1'b1, r, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            logic [80:0] blocked;
            new_req(blocked);
            cycle(1'b1, blocked, 1'b0, 1'b0);
        end
        cycle(1'b0, '0, 1'b1, 1'b1);

        // Fill to depth with back-to-back accepts; a same-cycle pop must not unblock
        for (int i = 0; i < 8; i++) begin
            new_req(r);
            cycle(1'b1, r, 1'b1, 1'b0);
        end
        check("full_count", 81'(count_o), 81'(8));
        new_req(r);
        cycle(1'b1, r, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Streaming push+pop across several pointer wraps
        new_req(r);
        cycle(1'b1, r, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            new_req(r);
            cycle(1'b1, r, 1'b1, 1'b1);
        end
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Underflow: sticky error until reset
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("underflow_err", 81'(err_o), 81'(1));
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Reset mid-operation: three entries queued, last AR still pending
        for (int i = 0; i < 3; i++) begin
            new_req(r);
            cycle(1'b1, r, 1'b1, 1'b0);
        end
        check("pre_rst_arvalid", 81'(arvalid_o), 81'(1));
        check("pre_rst_count", 81'(count_o), 81'(3));
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("post_rst_ready", 81'(req_ready_o), 81'(1));

        // Recovery after reset: normal write request flows through
        r = mk_req(1'b1, 16'hBEEF, 64'h0000_0000_1234_5640);
        cycle(1'b1, r, 1'b0, 1'b0);
        check("wr_araddr", 81'(araddr_o), 81'(64'h8));
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
